// File: rtl/vision_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vision_test_sequencer
//  Description : Trial sequencer for the 8x8 matrix vision tester. A confirm
//                press starts a test. Each trial shows an "E" pointing in a
//                pseudo-random direction, then collects a direction and a
//                confirm within a response window. It scores the answer
//                (2-of-3 per level) and steps the optotype size level. At the
//                end it reports how many levels were passed.
//  Ports       : clk, rst (async, active-low)
//                upper/lower/left/right/confirm : single-cycle button pulses
//                show        : glyph visible (awaiting a response)
//                glyph_dir   : 0 up, 1 down, 2 left, 3 right
//                glyph_level : current size level (0 = largest)
//                fb          : 0 none, 1 correct, 2 wrong, 3 timeout
//                busy / done : test running / test finished
//                result      : number of levels passed
//  Revision    : 1.0 - initial release
// ============================================================================
module vision_test_sequencer #(
    parameter int          LEVELS      = 6,
    parameter int          TIMEOUT_CYC = 50_000_000,
    parameter int          FB_CYC      = 5_000_000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upper,
    input  logic       lower,
    input  logic       left,
    input  logic       right,
    input  logic       confirm,
    output logic       show,
    output logic [1:0] glyph_dir,
    output logic [2:0] glyph_level,
    output logic [1:0] fb,
    output logic       busy,
    output logic       done,
    output logic [2:0] result
);

    // The response window and the feedback hold never overlap, so a single
    // counter sized for the longer of the two serves both.
    localparam int c_CNT_MAX = (TIMEOUT_CYC > FB_CYC) ? TIMEOUT_CYC : FB_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_FB_LAST  = c_CNT_W'(FB_CYC - 1);
    localparam logic [2:0]         c_LAST_LVL = 3'(LEVELS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESENT   = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_JUDGE     = 3'd3,
        S_FEEDBACK  = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [15:0]          r_lfsr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_dir;
    logic [1:0]           r_cand;
    logic                 r_cand_vld;
    logic [1:0]           r_hits;
    logic [1:0]           r_misses;
    logic [2:0]           r_level;
    logic [2:0]           r_result;
    logic [1:0]           r_fb;
    logic                 r_show;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_dir_any;
    logic [1:0]           w_pulse_dir;
    logic                 w_accept;
    logic                 w_timeout;
    logic                 w_fb_end;
    logic [1:0]           w_present_dir;
    logic                 w_lfsr_fb;

    assign w_dir_any = upper | lower | left | right;

    // Simultaneous presses resolve upper > lower > left > right.
    always_comb begin
        w_pulse_dir = 2'd3;
        if (upper) begin
            w_pulse_dir = 2'd0;
        end else if (lower) begin
            w_pulse_dir = 2'd1;
        end else if (left) begin
            w_pulse_dir = 2'd2;
        end
    end

    // A confirm counts only if there is something to judge: a latched
    // candidate or a direction pressed in the very same cycle.
    assign w_accept  = (r_state == S_WAIT_RESP) && confirm && (w_dir_any || r_cand_vld);
    assign w_timeout = (r_state == S_WAIT_RESP) && (r_cnt == c_TO_LAST);
    assign w_fb_end  = (r_state == S_FEEDBACK)  && (r_cnt == c_FB_LAST);

    // Never show the same direction twice in a row.
    assign w_present_dir = (r_lfsr[1:0] == r_dir) ? (r_lfsr[1:0] + 2'd1) : r_lfsr[1:0];

    // Fibonacci LFSR, taps 16,14,13,11.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (confirm) begin
                    w_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                w_next = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (w_accept || w_timeout) begin
                    w_next = S_JUDGE;
                end
            end
            S_JUDGE: begin
                w_next = S_FEEDBACK;
            end
            S_FEEDBACK: begin
                if (w_fb_end) begin
                    if (r_hits == 2'd2) begin
                        w_next = (r_level == c_LAST_LVL) ? S_DONE : S_PRESENT;
                    end else if (r_misses == 2'd2) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_PRESENT;
                    end
                end
            end
            S_DONE: begin
                if (confirm) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr     <= SEED;
            r_cnt      <= '0;
            r_dir      <= 2'd0;
            r_cand     <= 2'd0;
            r_cand_vld <= 1'b0;
            r_hits     <= 2'd0;
            r_misses   <= 2'd0;
            r_level    <= 3'd0;
            r_result   <= 3'd0;
            r_fb       <= 2'd0;
            r_show     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

            // Outputs track the state being entered, so they line up
            // with the state itself rather than lagging by a cycle.
            r_show <= (w_next == S_WAIT_RESP);
            r_busy <= (w_next == S_PRESENT) || (w_next == S_WAIT_RESP) ||
                      (w_next == S_JUDGE)   || (w_next == S_FEEDBACK);
            r_done <= (w_next == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (confirm) begin
                        r_level  <= 3'd0;
                        r_hits   <= 2'd0;
                        r_misses <= 2'd0;
                        r_result <= 3'd0;
                    end
                end
                S_PRESENT: begin
                    r_dir      <= w_present_dir;
                    r_cand     <= 2'd0;
                    r_cand_vld <= 1'b0;
                    r_cnt      <= '0;
                end
                S_WAIT_RESP: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_accept) begin
                        // Leave the judged answer in the candidate register.
                        r_cand     <= w_dir_any ? w_pulse_dir : r_cand;
                        r_cand_vld <= 1'b1;
                    end else if (w_timeout) begin
                        // An unconfirmed candidate is not an answer; the
                        // cleared flag marks the trial as timed out.
                        r_cand_vld <= 1'b0;
                    end else if (w_dir_any) begin
                        r_cand     <= w_pulse_dir;
                        r_cand_vld <= 1'b1;
                    end
                end
                S_JUDGE: begin
                    r_cnt <= '0;
                    if (!r_cand_vld) begin
                        r_misses <= r_misses + 2'd1;
                        r_fb     <= 2'd3;
                    end else if (r_cand == r_dir) begin
                        r_hits <= r_hits + 2'd1;
                        r_fb   <= 2'd1;
                    end else begin
                        r_misses <= r_misses + 2'd1;
                        r_fb     <= 2'd2;
                    end
                end
                S_FEEDBACK: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_fb_end) begin
                        r_fb <= 2'd0;
                        if (r_hits == 2'd2) begin
                            r_result <= r_level + 3'd1;
                            if (r_level != c_LAST_LVL) begin
                                r_level  <= r_level + 3'd1;
                                r_hits   <= 2'd0;
                                r_misses <= 2'd0;
                            end
                        end else if (r_misses == 2'd2) begin
                            r_result <= r_level;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign show        = r_show;
    assign glyph_dir   = r_dir;
    assign glyph_level = r_level;
    assign fb          = r_fb;
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;

endmodule
`default_nettype wire
